// File: rtl/fir_mc_engine_if.sv
// Handshake and coefficient bus of the multi-channel FIR engine.
// The engine takes the slave view; the sample source and sink take the master view.
interface fir_mc_engine_if #(
  parameter int WIDTH      = 16,
  parameter int COEF_WIDTH = 16,
  parameter int TAPS       = 30,
  parameter int CHANNELS   = 2,
  parameter int OUT_WIDTH  = 16
);
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int AW = $clog2(TAPS);

  logic                         in_valid;
  logic                         in_ready;
  logic [CW-1:0]                in_chan;
  logic signed [WIDTH-1:0]      data_in;
  logic                         coef_we;
  logic [AW-1:0]                coef_addr;
  logic signed [COEF_WIDTH-1:0] coef_data;
  logic                         out_valid;
  logic                         out_ready;
  logic [CW-1:0]                out_chan;
  logic signed [OUT_WIDTH-1:0]  data_out;
  logic                         busy;

  modport master (
    output in_valid, in_chan, data_in, coef_we, coef_addr, coef_data, out_ready,
    input  in_ready, out_valid, out_chan, data_out, busy
  );

  modport slave (
    input  in_valid, in_chan, data_in, coef_we, coef_addr, coef_data, out_ready,
    output in_ready, out_valid, out_chan, data_out, busy
  );
endinterface

// File: rtl/fir_mc_engine.sv
// Time-multiplexed multi-channel FIR: one shared MAC walks the taps of one channel's
// delay line per sample. Define SATURATE_EN to clamp the output instead of wrapping.
module fir_mc_engine #(
  parameter int WIDTH      = 16,
  parameter int COEF_WIDTH = 16,
  parameter int TAPS       = 30,
  parameter int CHANNELS   = 2,
  parameter int ACC_WIDTH  = 40,
  parameter int OUT_WIDTH  = 16,
  parameter int OUT_SHIFT  = 15
) (
  input  logic           clk,
  input  logic           rst_n,
  fir_mc_engine_if.slave bus
);
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int AW = $clog2(TAPS);
  localparam int TW = $clog2(TAPS + 1);
  localparam int PW = WIDTH + COEF_WIDTH;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MAC  = 2'd1;
  localparam logic [1:0] OUT  = 2'd2;

  localparam logic [TW-1:0] LAST_TAP   = TW'(TAPS);
  localparam logic [AW:0]   ADDR_LIMIT = (AW + 1)'(TAPS);
  localparam logic [CW:0]   CHAN_LIMIT = (CW + 1)'(CHANNELS);

  logic [1:0]                   state_q, state_d;
  logic [TW-1:0]                tap_q, tap_d;
  logic [CW-1:0]                chan_q, chan_d;
  logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic signed [PW-1:0]         prod_q, prod_d;
  logic signed [WIDTH-1:0]      x_q [CHANNELS][TAPS];
  logic signed [COEF_WIDTH-1:0] coef_q [TAPS];

  logic          sampleAccept;
  logic          coefWrite;
  logic [AW-1:0] macIdx;

  assign sampleAccept = (state_q == IDLE) && bus.in_valid && ({1'b0, bus.in_chan} < CHAN_LIMIT);
  assign coefWrite    = (state_q == IDLE) && bus.coef_we && ({1'b0, bus.coef_addr} < ADDR_LIMIT);
  assign macIdx       = (tap_q < LAST_TAP) ? tap_q[AW-1:0] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < CHANNELS; c++) begin
        for (int k = 0; k < TAPS; k++) begin
          x_q[c][k] <= '0;
        end
      end
      for (int k = 0; k < TAPS; k++) begin
        coef_q[k] <= '0;
      end
    end else begin
      if (coefWrite) begin
        coef_q[bus.coef_addr] <= bus.coef_data;
      end
      if (sampleAccept) begin
        x_q[bus.in_chan][0] <= bus.data_in;
        for (int k = 1; k < TAPS; k++) begin
          x_q[bus.in_chan][k] <= x_q[bus.in_chan][k-1];
        end
      end
    end
  end

  // The product is registered, so MAC spends one extra cycle draining the last product.
  always_comb begin
    state_d = state_q;
    tap_d   = tap_q;
    chan_d  = chan_q;
    acc_d   = acc_q;
    prod_d  = prod_q;
    case (state_q)
      IDLE: begin
        if (sampleAccept) begin
          state_d = MAC;
          tap_d   = '0;
          chan_d  = bus.in_chan;
          acc_d   = '0;
        end
      end
      MAC: begin
        if (tap_q != '0) begin
          acc_d = acc_q + ACC_WIDTH'(prod_q);
        end
        prod_d = PW'(x_q[chan_q][macIdx]) * PW'(coef_q[macIdx]);
        if (tap_q == LAST_TAP) begin
          state_d = OUT;
        end else begin
          tap_d = tap_q + 1'b1;
        end
      end
      OUT: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tap_q   <= '0;
      chan_q  <= '0;
      acc_q   <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      tap_q   <= tap_d;
      chan_q  <= chan_d;
      acc_q   <= acc_d;
      prod_q  <= prod_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.out_valid = (state_q == OUT);
  assign bus.out_chan  = chan_q;

`ifdef SATURATE_EN
  localparam logic signed [ACC_WIDTH-1:0] OUT_MAX = ACC_WIDTH'((64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1);
  localparam logic signed [ACC_WIDTH-1:0] OUT_MIN = ~OUT_MAX;

  logic signed [ACC_WIDTH-1:0] shifted;
  assign shifted = acc_q >>> OUT_SHIFT;

  always_comb begin
    if (shifted > OUT_MAX) begin
      bus.data_out = OUT_WIDTH'(OUT_MAX);
    end else if (shifted < OUT_MIN) begin
      bus.data_out = OUT_WIDTH'(OUT_MIN);
    end else begin
      bus.data_out = OUT_WIDTH'(shifted);
    end
  end
`else
  assign bus.data_out = OUT_WIDTH'(acc_q >>> OUT_SHIFT);
`endif
endmodule

// File: tb/tb_fir_mc_engine.sv
// Bench for fir_mc_engine: directed scenarios with hand-computed results plus
// randomized traffic, all compared against a sample-level FIR model every cycle.
module tb_fir_mc_engine;
  localparam int WIDTH      = 16;
  localparam int COEF_WIDTH = 16;
  localparam int TAPS       = 4;
  localparam int CHANNELS   = 2;
  localparam int ACC_WIDTH  = 40;
  localparam int OUT_WIDTH  = 16;
  localparam int OUT_SHIFT  = 0;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int checkCnt = 0;
  int passCnt  = 0;

  fir_mc_engine_if #(
    .WIDTH(WIDTH), .COEF_WIDTH(COEF_WIDTH), .TAPS(TAPS),
    .CHANNELS(CHANNELS), .OUT_WIDTH(OUT_WIDTH)
  ) dutIf ();

  fir_mc_engine #(
    .WIDTH(WIDTH), .COEF_WIDTH(COEF_WIDTH), .TAPS(TAPS), .CHANNELS(CHANNELS),
    .ACC_WIDTH(ACC_WIDTH), .OUT_WIDTH(OUT_WIDTH), .OUT_SHIFT(OUT_SHIFT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (dutIf)
  );

  always #5 clk = ~clk;

  logic signed [WIDTH-1:0]      histM [CHANNELS][TAPS];
  logic signed [COEF_WIDTH-1:0] coefM [TAPS];
  logic signed [OUT_WIDTH-1:0]  mData;
  bit     mBusy = 1'b0;
  int     cycleCnt = 0;
  int     mAcceptEdge = 0;
  int     mChan = 0;
  int     mCh;
  longint mSum;
  bit     expValid;

  task automatic check(input string name, input longint act, input longint exp);
    checkCnt++;
    if (act == exp) begin
      passCnt++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d at time %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic signed [OUT_WIDTH-1:0] reduceOut(input longint acc);
    longint s;
    longint maxV;
    s    = acc >>> OUT_SHIFT;
    maxV = (longint'(1) <<< (OUT_WIDTH - 1)) - 1;
`ifdef SATURATE_EN
    if (s > maxV) s = maxV;
    if (s < -maxV - 1) s = -maxV - 1;
`endif
    return s[OUT_WIDTH-1:0];
  endfunction

  // Sample-level model: each accepted sample yields one dot product, visible TAPS+1 edges later.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycleCnt    = 0;
      mBusy       = 1'b0;
      mAcceptEdge = 0;
      mData       = '0;
      mChan       = 0;
      foreach (histM[c, k]) histM[c][k] = '0;
      foreach (coefM[k]) coefM[k] = '0;
    end else begin
      cycleCnt++;
      if (mBusy) begin
        if ((cycleCnt - 1 >= mAcceptEdge + TAPS + 1) && dutIf.out_ready) mBusy = 1'b0;
      end else begin
        if (dutIf.coef_we && int'(dutIf.coef_addr) < TAPS) coefM[dutIf.coef_addr] = dutIf.coef_data;
        if (dutIf.in_valid && int'(dutIf.in_chan) < CHANNELS) begin
          mCh = int'(dutIf.in_chan);
          for (int k = TAPS - 1; k > 0; k--) histM[mCh][k] = histM[mCh][k-1];
          histM[mCh][0] = dutIf.data_in;
          mSum = 0;
          for (int k = 0; k < TAPS; k++) mSum += longint'(histM[mCh][k]) * longint'(coefM[k]);
          mData       = reduceOut(mSum);
          mChan       = mCh;
          mBusy       = 1'b1;
          mAcceptEdge = cycleCnt;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      expValid = mBusy && (cycleCnt >= mAcceptEdge + TAPS + 1);
      check("in_ready", dutIf.in_ready, !mBusy);
      check("busy", dutIf.busy, mBusy);
      check("out_valid", dutIf.out_valid, expValid);
      if (expValid) begin
        check("data_out", dutIf.data_out, mData);
        check("out_chan", dutIf.out_chan, mChan);
      end
    end
  end

  task automatic applyStimulus(input int ch, input int d);
    int n = 0;
    while (!dutIf.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!dutIf.in_ready) begin
      checkCnt++;
      $display("[TB] FAIL accept_timeout: in_ready got 0, expected 1");
      return;
    end
    dutIf.in_valid = 1'b1;
    dutIf.in_chan  = 1'(ch);
    dutIf.data_in  = 16'(d);
    @(negedge clk);
    dutIf.in_valid = 1'b0;
  endtask

  task automatic waitValid(input string name, output bit ok);
    int n = 0;
    while (!dutIf.out_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    ok = dutIf.out_valid;
    if (!ok) begin
      checkCnt++;
      $display("[TB] FAIL %s_timeout: out_valid got 0, expected 1", name);
    end
  endtask

  task automatic checkOutput(input longint expData, input int expChan, input bit pin, input string name);
    bit ok;
    waitValid(name, ok);
    if (!ok) return;
    if (pin) begin
      check({name, "_data"}, dutIf.data_out, expData);
      check({name, "_chan"}, dutIf.out_chan, expChan);
    end
    dutIf.out_ready = 1'b1;
    @(negedge clk);
    dutIf.out_ready = 1'b0;
  endtask

  task automatic loadCoefs(input int c0, input int c1, input int c2, input int c3);
    int cs [TAPS];
    cs = '{c0, c1, c2, c3};
    for (int k = 0; k < TAPS; k++) begin
      dutIf.coef_we   = 1'b1;
      dutIf.coef_addr = 2'(k);
      dutIf.coef_data = 16'(cs[k]);
      @(negedge clk);
    end
    dutIf.coef_we = 1'b0;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit ok;
    dutIf.in_valid  = 1'b0;
    dutIf.in_chan   = '0;
    dutIf.data_in   = '0;
    dutIf.coef_we   = 1'b0;
    dutIf.coef_addr = '0;
    dutIf.coef_data = '0;
    dutIf.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", dutIf.out_valid, 0);
    check("rst_data_out", dutIf.data_out, 0);
    check("rst_out_chan", dutIf.out_chan, 0);
    check("rst_busy", dutIf.busy, 0);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", dutIf.in_ready, 1);

    // Impulse response through c = {1,2,3,4}.
    loadCoefs(1, 2, 3, 4);
    applyStimulus(0, 1); checkOutput(1, 0, 1'b1, "t1_o0");
    applyStimulus(0, 0); checkOutput(2, 0, 1'b1, "t1_o1");
    applyStimulus(0, 0); checkOutput(3, 0, 1'b1, "t1_o2");
    applyStimulus(0, 0); checkOutput(4, 0, 1'b1, "t1_o3");
    applyStimulus(0, 0); checkOutput(0, 0, 1'b1, "t1_o4");

    applyStimulus(0, 1);   checkOutput(1, 0, 1'b1, "t2_ch0a");
    applyStimulus(1, 100); checkOutput(100, 1, 1'b1, "t2_ch1");
    applyStimulus(0, 0);   checkOutput(2, 0, 1'b1, "t2_ch0b");

    // Backpressure: ch1 history {0,100,0,0} gives 200 and must hold still.
    applyStimulus(1, 0);
    waitValid("t3", ok);
    if (ok) begin
      for (int i = 0; i < 5; i++) begin
        check("t3_hold_data", dutIf.data_out, 200);
        check("t3_hold_chan", dutIf.out_chan, 1);
        check("t3_hold_in_ready", dutIf.in_ready, 0);
        dutIf.in_valid = 1'b1;
        dutIf.in_chan  = 1'b0;
        dutIf.data_in  = 16'd77;
        @(negedge clk);
      end
      dutIf.in_valid  = 1'b0;
      dutIf.out_ready = 1'b1;
      @(negedge clk);
      dutIf.out_ready = 1'b0;
      check("t3_after_out_valid", dutIf.out_valid, 0);
      check("t3_after_in_ready", dutIf.in_ready, 1);
    end

    // Write during MAC is ignored; write on the accept edge takes effect.
    applyStimulus(0, 2);
    dutIf.coef_we   = 1'b1;
    dutIf.coef_addr = 2'd0;
    dutIf.coef_data = 16'sd9;
    @(negedge clk);
    dutIf.coef_we = 1'b0;
    checkOutput(5, 0, 1'b1, "t5_busy_write");
    dutIf.coef_we   = 1'b1;
    dutIf.coef_addr = 2'd0;
    dutIf.coef_data = 16'sd7;
    applyStimulus(0, 1);
    dutIf.coef_we = 1'b0;
    checkOutput(15, 0, 1'b1, "t5_same_edge");

    loadCoefs(32767, 32767, 32767, 32767);
    for (int i = 0; i < TAPS; i++) begin
      applyStimulus(0, 0);
      checkOutput(0, 0, 1'b0, "t4_flush");
    end
    for (int i = 0; i < TAPS; i++) begin
      applyStimulus(0, 32767);
`ifdef SATURATE_EN
      checkOutput(32767, 0, 1'b1, "t4_ovf");
`else
      checkOutput(i + 1, 0, 1'b1, "t4_ovf");
`endif
    end

    // Reset in MAC, then reset in OUT; coefficients are cleared afterwards.
    applyStimulus(0, 3);
    #2 rst_n = 1'b0;
    #1;
    check("t6_mac_busy", dutIf.busy, 0);
    check("t6_mac_out_valid", dutIf.out_valid, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    applyStimulus(0, 5);
    waitValid("t6_out", ok);
    if (ok) begin
      check("t6_cleared_data", dutIf.data_out, 0);
      #2 rst_n = 1'b0;
      #1;
      check("t6_out_out_valid", dutIf.out_valid, 0);
      check("t6_out_busy", dutIf.busy, 0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
    end

    for (int i = 0; i < 1500; i++) begin
      dutIf.in_valid  = ($urandom_range(0, 2) == 0);
      dutIf.in_chan   = 1'($urandom);
      dutIf.data_in   = 16'($urandom);
      dutIf.coef_we   = ($urandom_range(0, 7) == 0);
      dutIf.coef_addr = 2'($urandom);
      dutIf.coef_data = 16'($urandom);
      dutIf.out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
    end
    dutIf.in_valid  = 1'b0;
    dutIf.coef_we   = 1'b0;
    dutIf.out_ready = 1'b1;
    repeat (20) @(negedge clk);

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end
endmodule
